// File: rtl/cpu_types_pkg.sv
// Types and defaults shared by the scalar ALU and the vector ALU pipeline.
// The ALU opcode encoding must stay identical between the two datapaths.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int VLANES = 4;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    logic of;
    logic zf;
    logic nf;
  } vlane_flags_t;

  function automatic logic is_addsub(input aluop_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/vector_alu_lane.sv
// One SIMD lane: purely combinational, bit-exact with the scalar ALU, plus an
// optional saturating clamp for ADD/SUB.
module vector_alu_lane
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = cpu_types_pkg::WORD_W,
  parameter int SH_W   = $clog2(WORD_W)
) (
  input  aluop_t              op_i,
  input  logic                sat_i,
  input  logic [WORD_W-1:0]   a_i,
  input  logic [WORD_W-1:0]   b_i,
  output logic [WORD_W-1:0]   res_o,
  output vlane_flags_t        flags_o
);

  localparam logic [WORD_W-1:0] SMAX = {1'b0, {(WORD_W-1){1'b1}}};
  localparam logic [WORD_W-1:0] SMIN = {1'b1, {(WORD_W-1){1'b0}}};

  logic [WORD_W-1:0] sum_s;
  logic [WORD_W-1:0] diff_s;
  logic [WORD_W-1:0] raw_s;
  logic [SH_W-1:0]   shamt_s;
  logic              of_s;
  logic              a_msb_s;
  logic              b_msb_s;

  assign sum_s   = a_i + b_i;
  assign diff_s  = a_i - b_i;
  assign shamt_s = b_i[SH_W-1:0];
  assign a_msb_s = a_i[WORD_W-1];
  assign b_msb_s = b_i[WORD_W-1];

  always_comb begin
    raw_s = '0;
    of_s  = 1'b0;
    case (op_i)
      ALU_SLL:  raw_s = a_i << shamt_s;
      ALU_SRL:  raw_s = a_i >> shamt_s;
      ALU_ADD: begin
        raw_s = sum_s;
        of_s  = ~(a_msb_s ^ b_msb_s) & (a_msb_s ^ sum_s[WORD_W-1]);
      end
      ALU_SUB: begin
        raw_s = diff_s;
        of_s  = (a_msb_s ^ b_msb_s) & (a_msb_s ^ diff_s[WORD_W-1]);
      end
      ALU_AND:  raw_s = a_i & b_i;
      ALU_OR:   raw_s = a_i | b_i;
      ALU_XOR:  raw_s = a_i ^ b_i;
      ALU_NOR:  raw_s = ~(a_i | b_i);
      ALU_SLT:  raw_s = {{(WORD_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: raw_s = {{(WORD_W-1){1'b0}}, (a_i < b_i)};
      default: begin
        raw_s = '0;
        of_s  = 1'b0;
      end
    endcase
  end

  // of_s is only ever set by ADD/SUB, so sat has no effect on other ops.
  assign res_o   = (sat_i && of_s && is_addsub(op_i)) ? (a_msb_s ? SMIN : SMAX) : raw_s;
  assign flags_o = '{of: of_s, zf: (res_o == '0), nf: res_o[WORD_W-1]};

endmodule

// File: rtl/vector_alu_pipe.sv
// Two-stage pipelined SIMD ALU with valid/ready handshake, lane masking,
// scalar broadcast of operand B and lane-reduced zero/overflow flags.
module vector_alu_pipe
  import cpu_types_pkg::*;
#(
  parameter int LANES  = VLANES,
  parameter int WORD_W = cpu_types_pkg::WORD_W,
  parameter int SH_W   = $clog2(WORD_W)
) (
  input  logic                      CLK,
  input  logic                      nRST,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  aluop_t                    op,
  input  logic                      sat,
  input  logic                      b_bcast,
  input  logic [LANES-1:0]          lane_mask,
  input  logic [LANES*WORD_W-1:0]   porta,
  input  logic [LANES*WORD_W-1:0]   portb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*WORD_W-1:0]   out,
  output logic [LANES-1:0]          of,
  output logic [LANES-1:0]          zf,
  output logic [LANES-1:0]          nf,
  output logic [LANES-1:0]          mask_out,
  output logic                      all_zf,
  output logic                      any_of
);

  localparam int VW = LANES * WORD_W;

  logic s2_adv_s;
  logic s1_adv_s;

  logic [VW-1:0]    b_eff_s;
  logic             s1_valid_q, s1_valid_d;
  aluop_t           s1_op_q,    s1_op_d;
  logic             s1_sat_q,   s1_sat_d;
  logic [LANES-1:0] s1_mask_q,  s1_mask_d;
  logic [VW-1:0]    s1_a_q,     s1_a_d;
  logic [VW-1:0]    s1_b_q,     s1_b_d;

  logic [VW-1:0]    lane_res_s;
  vlane_flags_t     lane_flags_s [LANES];
  logic [VW-1:0]    mres_s;
  logic [LANES-1:0] mof_s, mzf_s, mnf_s;
  logic             mall_zf_s, many_of_s;

  logic             s2_valid_q,  s2_valid_d;
  logic [VW-1:0]    s2_res_q,    s2_res_d;
  logic [LANES-1:0] s2_of_q,     s2_of_d;
  logic [LANES-1:0] s2_zf_q,     s2_zf_d;
  logic [LANES-1:0] s2_nf_q,     s2_nf_d;
  logic [LANES-1:0] s2_mask_q,   s2_mask_d;
  logic             s2_all_zf_q, s2_all_zf_d;
  logic             s2_any_of_q, s2_any_of_d;

  // Ready propagates backwards combinationally; nothing depends on in_valid.
  assign s2_adv_s = ~s2_valid_q | out_ready;
  assign s1_adv_s = ~s1_valid_q | s2_adv_s;
  assign in_ready = s1_adv_s;

  always_comb begin
    b_eff_s = '0;
    for (int i = 0; i < LANES; i++) begin
      if (b_bcast) begin
        b_eff_s[i*WORD_W +: WORD_W] = portb[WORD_W-1:0];
      end else begin
        b_eff_s[i*WORD_W +: WORD_W] = portb[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_sat_d   = s1_sat_q;
    s1_mask_d  = s1_mask_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d   = op;
        s1_sat_d  = sat;
        s1_mask_d = lane_mask;
        s1_a_d    = porta;
        s1_b_d    = b_eff_s;
      end else begin
        s1_op_d   = s1_op_q;
        s1_sat_d  = s1_sat_q;
        s1_mask_d = s1_mask_q;
        s1_a_d    = s1_a_q;
        s1_b_d    = s1_b_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= ALU_SLL;
      s1_sat_q   <= 1'b0;
      s1_mask_q  <= '0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_sat_q   <= s1_sat_d;
      s1_mask_q  <= s1_mask_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    vector_alu_lane #(
      .WORD_W (WORD_W),
      .SH_W   (SH_W)
    ) u_lane (
      .op_i    (s1_op_q),
      .sat_i   (s1_sat_q),
      .a_i     (s1_a_q[g*WORD_W +: WORD_W]),
      .b_i     (s1_b_q[g*WORD_W +: WORD_W]),
      .res_o   (lane_res_s[g*WORD_W +: WORD_W]),
      .flags_o (lane_flags_s[g])
    );
  end

  // Inactive lanes are forced to zero before the flag reductions.
  always_comb begin
    mres_s = '0;
    mof_s  = '0;
    mzf_s  = '0;
    mnf_s  = '0;
    for (int i = 0; i < LANES; i++) begin
      if (s1_mask_q[i]) begin
        mres_s[i*WORD_W +: WORD_W] = lane_res_s[i*WORD_W +: WORD_W];
        mof_s[i] = lane_flags_s[i].of;
        mzf_s[i] = lane_flags_s[i].zf;
        mnf_s[i] = lane_flags_s[i].nf;
      end else begin
        mres_s[i*WORD_W +: WORD_W] = '0;
        mof_s[i] = 1'b0;
        mzf_s[i] = 1'b0;
        mnf_s[i] = 1'b0;
      end
    end
  end

  assign mall_zf_s = &(mzf_s | ~s1_mask_q);
  assign many_of_s = |mof_s;

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_res_d    = s2_res_q;
    s2_of_d     = s2_of_q;
    s2_zf_d     = s2_zf_q;
    s2_nf_d     = s2_nf_q;
    s2_mask_d   = s2_mask_q;
    s2_all_zf_d = s2_all_zf_q;
    s2_any_of_d = s2_any_of_q;
    if (s2_adv_s) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_res_d    = mres_s;
        s2_of_d     = mof_s;
        s2_zf_d     = mzf_s;
        s2_nf_d     = mnf_s;
        s2_mask_d   = s1_mask_q;
        s2_all_zf_d = mall_zf_s;
        s2_any_of_d = many_of_s;
      end else begin
        s2_res_d    = s2_res_q;
        s2_all_zf_d = s2_all_zf_q;
        s2_any_of_d = s2_any_of_q;
      end
    end else begin
      s2_valid_d = s2_valid_q;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      s2_valid_q  <= 1'b0;
      s2_res_q    <= '0;
      s2_of_q     <= '0;
      s2_zf_q     <= '0;
      s2_nf_q     <= '0;
      s2_mask_q   <= '0;
      s2_all_zf_q <= 1'b0;
      s2_any_of_q <= 1'b0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_res_q    <= s2_res_d;
      s2_of_q     <= s2_of_d;
      s2_zf_q     <= s2_zf_d;
      s2_nf_q     <= s2_nf_d;
      s2_mask_q   <= s2_mask_d;
      s2_all_zf_q <= s2_all_zf_d;
      s2_any_of_q <= s2_any_of_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out       = s2_res_q;
  assign of        = s2_of_q;
  assign zf        = s2_zf_q;
  assign nf        = s2_nf_q;
  assign mask_out  = s2_mask_q;
  assign all_zf    = s2_all_zf_q;
  assign any_of    = s2_any_of_q;

endmodule
